// File: rtl/pll_reset_pkg.sv
// pll_reset_pkg: shared state encoding, default parameters and counter-width helper for the PLL reset sequencer.
package pll_reset_pkg;
    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        RUN       = 2'd2,
        LOST      = 2'd3
    } state_e;
    localparam int unsigned DEF_SYNC_STAGES        = 2;
    localparam int unsigned DEF_LOCK_STABLE_CYCLES = 1024;
    localparam int unsigned DEF_HOLD_CYCLES        = 16;
    localparam int unsigned DEF_COUNT_WIDTH        = 8;
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/bit_sync.sv
// bit_sync: N-stage single-bit synchronizer with asynchronous active-low clear.
module bit_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);
    logic [STAGES-1:0] sync_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= '0;
        else         sync_q <= {sync_q[STAGES-2:0], d_i};
    end
    assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: holds system reset until the PLL lock flag has been stable, and re-sequences on lock loss.
module pll_reset_sequencer
    import pll_reset_pkg::*;
#(
    parameter int unsigned SYNC_STAGES        = DEF_SYNC_STAGES,
    parameter int unsigned LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned HOLD_CYCLES        = DEF_HOLD_CYCLES,
    parameter int unsigned COUNT_WIDTH        = DEF_COUNT_WIDTH
) (
    input  logic                   clk_50mhz,
    input  logic                   rst_n,
    input  logic                   locked,
    output logic                   sys_rst_n,
    output logic                   pll_ok,
    output logic [COUNT_WIDTH-1:0] lock_loss_count
);
    localparam int unsigned SW = cnt_width(LOCK_STABLE_CYCLES);
    localparam int unsigned HW = cnt_width(HOLD_CYCLES);
    logic                   locked_s;
    state_e                 state_q, state_d;
    logic [SW-1:0]          stable_q, stable_d;
    logic [HW-1:0]          hold_q, hold_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   sys_q;
    bit_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk_i  (clk_50mhz),
        .rst_ni (rst_n),
        .d_i    (locked),
        .q_o    (locked_s)
    );
    always_comb begin
        state_d  = state_q;
        stable_d = stable_q;
        hold_d   = hold_q;
        count_d  = count_q;
        case (state_q)
            WAIT_LOCK: if (locked_s) begin
                state_d  = STABILIZE;
                stable_d = '0;
            end
            STABILIZE: begin
                if (!locked_s) state_d = WAIT_LOCK;
                else if (stable_q == SW'(LOCK_STABLE_CYCLES - 1)) state_d = RUN;
                else stable_d = stable_q + 1'b1;
            end
            RUN: if (!locked_s) begin
                state_d = LOST;
                hold_d  = '0;
                count_d = (&count_q) ? count_q : count_q + 1'b1;
            end
            LOST: begin
                // the hold always runs to completion, even if lock returns early
                if (hold_q == HW'(HOLD_CYCLES - 1)) state_d = WAIT_LOCK;
                else hold_d = hold_q + 1'b1;
            end
            default: state_d = WAIT_LOCK;
        endcase
    end
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= WAIT_LOCK;
            stable_q <= '0;
            hold_q   <= '0;
            count_q  <= '0;
            sys_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            stable_q <= stable_d;
            hold_q   <= hold_d;
            count_q  <= count_d;
            sys_q    <= (state_d == RUN);
        end
    end
    assign sys_rst_n       = sys_q;
    assign pll_ok          = locked_s;
    assign lock_loss_count = count_q;
endmodule
